// File: rtl/instr_fetch_unit.sv
// Instruction-fetch front end: PC and instruction register, PC update mux,
// and a req/ack fetch FSM with a timeout that abandons a stuck fetch.
module instr_fetch_unit #(
    parameter int unsigned        ADDR_W      = 32,
    parameter int unsigned        DATA_W      = 32,
    parameter logic [ADDR_W-1:0]  RESET_PC    = '0,
    parameter int unsigned        TIMEOUT_CYC = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ir_write,
    input  logic              pc_write,
    input  logic              pc_write_cond,
    input  logic              branch_type,
    input  logic [1:0]        pc_source,
    input  logic [ADDR_W-1:0] alu_result,
    input  logic [ADDR_W-1:0] alu_out,
    input  logic              alu_zero,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [DATA_W-1:0] imem_rdata,
    input  logic              imem_ack,
    output logic [ADDR_W-1:0] pc,
    output logic [DATA_W-1:0] instr,
    output logic [5:0]        opcode,
    output logic              ir_valid,
    output logic              fetch_busy,
    output logic              fetch_err
);

    localparam int unsigned      CNT_W   = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYC - 1);

    typedef enum logic {
        S_IDLE,
        S_REQ
    } state_t;

    state_t             r_state;
    state_t             w_state_next;
    logic [CNT_W-1:0]   r_count;
    logic [CNT_W-1:0]   w_count_next;
    logic [ADDR_W-1:0]  r_pc;
    logic [ADDR_W-1:0]  w_pc_next;
    logic [ADDR_W-1:0]  r_addr;
    logic [DATA_W-1:0]  r_instr;
    logic               r_ir_valid;
    logic               r_err;
    logic               w_pc_en;
    logic               w_start;
    logic               w_load;
    logic               w_timeout;

    // PC update path runs independently of the fetch FSM
    assign w_pc_en = pc_write | (pc_write_cond & (alu_zero ^ branch_type));

    always_comb begin
        w_pc_next = r_pc;
        case (pc_source)
            2'b00:   w_pc_next = alu_result;
            2'b01:   w_pc_next = alu_out;
            2'b10:   w_pc_next = {r_pc[ADDR_W-1:26], r_instr[25:0]};
            default: w_pc_next = r_pc;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Ack takes priority over timeout when both land on the final REQ cycle
    always_comb begin
        w_state_next = r_state;
        w_count_next = r_count;
        w_start      = 1'b0;
        w_load       = 1'b0;
        w_timeout    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (ir_write) begin
                    w_start      = 1'b1;
                    w_count_next = '0;
                    w_state_next = S_REQ;
                end
            end
            S_REQ: begin
                if (imem_ack) begin
                    w_load       = 1'b1;
                    w_state_next = S_IDLE;
                end else if (r_count == CNT_MAX) begin
                    w_timeout    = 1'b1;
                    w_state_next = S_IDLE;
                end else begin
                    w_count_next = r_count + CNT_W'(1);
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_pc       <= RESET_PC;
            r_instr    <= '0;
            r_addr     <= '0;
            r_count    <= '0;
            r_ir_valid <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            r_count    <= w_count_next;
            r_ir_valid <= w_load;
            if (w_pc_en) begin
                r_pc <= w_pc_next;
            end
            if (w_start) begin
                r_addr <= r_pc;
            end
            if (w_load) begin
                r_instr <= imem_rdata;
            end else if (w_timeout) begin
                r_instr <= '0;
            end
            if (w_timeout) begin
                r_err <= 1'b1;
            end
        end
    end

    assign imem_req   = (r_state == S_REQ);
    assign fetch_busy = (r_state == S_REQ);
    assign imem_addr  = r_addr;
    assign pc         = r_pc;
    assign instr      = r_instr;
    assign opcode     = r_instr[DATA_W-1 -: 6];
    assign ir_valid   = r_ir_valid;
    assign fetch_err  = r_err;

endmodule
